// File: rtl/logic_pipe_unit.sv
// logic_pipe_unit: pipelined bitwise logic unit (AND/OR/XOR/NOR) with result
// flags, a valid/ready handshake and full backpressure.
// Parameters: WIDTH (operand width, >= 1), STAGES (pipeline depth, 1..4).
// Optional feature: define LOGIC_PIPE_PARITY_EN to add out_parity, the
// XOR-reduction of the result, carried through the pipeline like the flags.
module logic_pipe_unit #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_zero,
   output logic             out_ones,
`ifdef LOGIC_PIPE_PARITY_EN
   output logic             out_parity,
`endif
   output logic [2:0]       occupancy,
   output logic             busy
);

   typedef enum logic [1:0] {
      OP_AND = 2'b00,
      OP_OR  = 2'b01,
      OP_XOR = 2'b10,
      OP_NOR = 2'b11
   } op_e;

   // Everything a stage carries; flags are resolved once at stage 0.
   typedef struct packed {
      logic [WIDTH-1:0] result;
      logic             zero;
      logic             ones;
`ifdef LOGIC_PIPE_PARITY_EN
      logic             parity;
`endif
   } beat_t;

   beat_t             data_q [STAGES];
   logic [STAGES-1:0] valid_q;
   logic [STAGES-1:0] take;     // stage may load this cycle
   logic [STAGES-1:0] adv;      // stage hands its beat onward this cycle
   logic [WIDTH-1:0]  res_d;
   beat_t             beat_d;
   logic              accept;
   logic              retire;
   logic [2:0]        occ_q;

   // Stage-0 payload: operation and flags computed ahead of capture.
   always_comb begin
      // NOTE: every variable gets a default before the case so no latch is inferred.
      res_d = '0;
      case (op_e'(in_op))
         OP_AND:  res_d = in_a & in_b;
         OP_OR:   res_d = in_a | in_b;
         OP_XOR:  res_d = in_a ^ in_b;
         OP_NOR:  res_d = ~(in_a | in_b);
         default: res_d = '0;
      endcase
      beat_d        = '0;
      beat_d.result = res_d;
      beat_d.zero   = ~|res_d;
      beat_d.ones   = &res_d;
`ifdef LOGIC_PIPE_PARITY_EN
      beat_d.parity = ^res_d;
`endif
   end

   // Ready chain from out_ready back to stage 0; a full stage may still load
   // when it is emptying in the same cycle, so there are no bubbles.
   always_comb begin
      adv  = '0;
      take = '0;
      adv[STAGES-1]  = valid_q[STAGES-1] & out_ready;
      take[STAGES-1] = ~valid_q[STAGES-1] | adv[STAGES-1];
      for (int k = STAGES - 2; k >= 0; k--) begin
         adv[k]  = valid_q[k] & take[k+1];
         take[k] = ~valid_q[k] | adv[k];
      end
   end

   assign in_ready = take[0];
   assign accept   = in_valid & take[0];
   assign retire   = adv[STAGES-1];

   // Pipeline registers: a stage that cannot load holds valid and data.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= '0;
         // NOTE: the stage array is a handful of flops, not RAM, so clearing it on reset is cheap and keeps out_result at 0 after reset.
         for (int k = 0; k < STAGES; k++) data_q[k] <= '0;
      end else begin
         // NOTE: non-blocking assignments so each stage reads its predecessor's pre-edge value.
         if (take[0]) valid_q[0] <= in_valid;
         if (accept)  data_q[0]  <= beat_d;
         for (int k = 1; k < STAGES; k++) begin
            if (take[k])  valid_q[k] <= adv[k-1];
            if (adv[k-1]) data_q[k]  <= data_q[k-1];
         end
      end
   end

   // Occupancy counter: +1 on accept-only, -1 on retire-only.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         occ_q <= '0;
      end else begin
         occ_q <= occ_q + {2'b00, accept} - {2'b00, retire};
      end
   end

   assign out_valid  = valid_q[STAGES-1];
   assign out_result = data_q[STAGES-1].result;
   assign out_zero   = out_valid & data_q[STAGES-1].zero;
   assign out_ones   = out_valid & data_q[STAGES-1].ones;
`ifdef LOGIC_PIPE_PARITY_EN
   assign out_parity = out_valid & data_q[STAGES-1].parity;
`endif
   assign occupancy  = occ_q;
   assign busy       = (occ_q != 3'd0);

endmodule
